// File: rtl/neighbor_id_fetch_cntl_if.sv
// ---------------------------------------------------------------------------
// neighbor_id_fetch_cntl_if
// Bundles the three buses of the neighbor-ID fetch controller.
//   Entry push  : in_valid, in_addr {base,len}, in_PE_tag, Neighbor_ID_FIFO_full
//   SRAM read   : sram_A, sram_CEN (active low), sram_Q
//   ID output   : out_valid, out_ready, out_nb_id, out_PE_tag, out_last
//   Status      : busy, overflow_err
// slave  = controller view, master = environment (upstream/SRAM/consumer).
// ---------------------------------------------------------------------------
interface neighbor_id_fetch_cntl_if #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 5,
  parameter int TAG_W  = 2,
  parameter int ID_W   = 16
);
  logic                      in_valid;
  logic [ADDR_W-1:0]         in_addr;
  logic [TAG_W-1:0]          in_PE_tag;
  logic                      Neighbor_ID_FIFO_full;
  logic [ADDR_W-LEN_W-1:0]   sram_A;
  logic                      sram_CEN;
  logic [ID_W-1:0]           sram_Q;
  logic                      out_valid;
  logic                      out_ready;
  logic [ID_W-1:0]           out_nb_id;
  logic [TAG_W-1:0]          out_PE_tag;
  logic                      out_last;
  logic                      busy;
  logic                      overflow_err;

  modport slave (
    input  in_valid, in_addr, in_PE_tag, sram_Q, out_ready,
    output Neighbor_ID_FIFO_full, sram_A, sram_CEN,
           out_valid, out_nb_id, out_PE_tag, out_last, busy, overflow_err
  );

  modport master (
    output in_valid, in_addr, in_PE_tag, sram_Q, out_ready,
    input  Neighbor_ID_FIFO_full, sram_A, sram_CEN,
           out_valid, out_nb_id, out_PE_tag, out_last, busy, overflow_err
  );
endinterface

// File: rtl/neighbor_id_fetch_cntl.sv
// ---------------------------------------------------------------------------
// neighbor_id_fetch_cntl
// Queues neighbor-info entries {base, len, tag} and expands each into len
// consecutive reads of the neighbor-ID SRAM (base .. base+len-1, wrapping),
// streaming the returned IDs through a 2-entry output queue with a
// valid/ready handshake. out_last marks the final ID of each entry.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high
//   bus   - neighbor_id_fetch_cntl_if.slave (push, SRAM, output, status)
// Optional feature: define NB_ID_FIFO_OVF_CHECK_EN to get a sticky
// overflow_err on pushes into a full entry FIFO (otherwise tied 0 and
// dropped pushes are silent).
// ---------------------------------------------------------------------------
module neighbor_id_fetch_cntl #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 5,
  parameter int TAG_W  = 2,
  parameter int ID_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  neighbor_id_fetch_cntl_if.slave   bus
);
  localparam int BASE_W = ADDR_W - LEN_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int ENT_W  = ADDR_W + TAG_W;
  localparam int OQ_W   = ID_W + TAG_W + 1;
  localparam logic [PTR_W:0] FULL_CNT   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] MARGIN_CNT = (PTR_W+1)'(DEPTH - 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  // ---------------- entry FIFO ----------------
  logic [ENT_W-1:0]  fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]    count_reg, count_next;
  logic              full_reg;
  logic              push, pop;
  logic [ENT_W-1:0]  fifo_rd;
  logic [LEN_W-1:0]  fifo_len;

  // Acceptance uses start-of-cycle occupancy only.
  assign push     = bus.in_valid && (count_reg < FULL_CNT);
  assign fifo_rd  = fifo_mem[rd_ptr_reg];
  assign fifo_len = fifo_rd[TAG_W+LEN_W-1:TAG_W];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {bus.in_addr, bus.in_PE_tag};
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop)      count_next = count_reg + 1'b1;
    else if (!push && pop) count_next = count_reg - 1'b1;
  end

  // ---------------- expansion FSM ----------------
  logic [1:0]        state_reg, state_next;
  logic [BASE_W-1:0] base_reg;
  logic [LEN_W-1:0]  len_reg, k_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic              last_k, issue, credit_ok;

  // Output-queue bookkeeping
  logic [1:0]        oq_count_reg, oq_count_next, oq_eff, credit_sum;
  logic              oq_wr_reg, oq_rd_reg, oq_pop;
  logic              inflight_reg, if_last_reg;
  logic [TAG_W-1:0]  if_tag_reg;
  logic [OQ_W-1:0]   oq_mem [2];

  assign pop    = (state_reg == LOAD);
  assign last_k = (k_reg == len_reg - 1'b1);
  assign oq_pop = (oq_count_reg != 2'd0) && bus.out_ready;

  // Credit counts the slot freed by a same-cycle pop, so a read can be
  // issued every cycle while the consumer keeps accepting.
  assign oq_eff     = oq_count_reg - {1'b0, oq_pop};
  assign credit_sum = oq_eff + {1'b0, inflight_reg};
  assign credit_ok  = (credit_sum < 2'd2);
  assign issue      = (state_reg == ISSUE) && credit_ok;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (count_reg != '0) state_next = LOAD;
      LOAD:    state_next = (fifo_len != '0) ? ISSUE : IDLE;
      ISSUE:   if (issue && last_k) state_next = (count_reg != '0) ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    oq_count_next = oq_count_reg;
    if (inflight_reg && !oq_pop)      oq_count_next = oq_count_reg + 1'b1;
    else if (!inflight_reg && oq_pop) oq_count_next = oq_count_reg - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      base_reg     <= '0;
      len_reg      <= '0;
      tag_reg      <= '0;
      k_reg        <= '0;
      inflight_reg <= 1'b0;
      if_tag_reg   <= '0;
      if_last_reg  <= 1'b0;
      oq_wr_reg    <= 1'b0;
      oq_rd_reg    <= 1'b0;
      oq_count_reg <= 2'd0;
    end else begin
      state_reg <= state_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      full_reg  <= (count_next >= MARGIN_CNT);

      if (pop) begin
        base_reg <= fifo_rd[ENT_W-1:TAG_W+LEN_W];
        len_reg  <= fifo_len;
        tag_reg  <= fifo_rd[TAG_W-1:0];
        k_reg    <= '0;
      end else if (issue) begin
        k_reg <= k_reg + 1'b1;
      end

      // Tag/last travel with the read so a following LOAD cannot alter them.
      inflight_reg <= issue;
      if (issue) begin
        if_tag_reg  <= tag_reg;
        if_last_reg <= last_k;
      end

      if (inflight_reg) oq_wr_reg <= ~oq_wr_reg;
      if (oq_pop)       oq_rd_reg <= ~oq_rd_reg;
      oq_count_reg <= oq_count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_oq
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          oq_mem[gi] <= '0;
        else if (inflight_reg && (oq_wr_reg == 1'(gi)))
          oq_mem[gi] <= {bus.sram_Q, if_tag_reg, if_last_reg};
      end
    end
  endgenerate

  // ---------------- outputs ----------------
  assign bus.sram_CEN              = ~issue;
  assign bus.sram_A                = base_reg + BASE_W'(k_reg);
  assign bus.Neighbor_ID_FIFO_full = full_reg;
  assign bus.out_valid             = (oq_count_reg != 2'd0);
  assign {bus.out_nb_id, bus.out_PE_tag, bus.out_last} = oq_mem[oq_rd_reg];
  assign bus.busy = (count_reg != '0) || (state_reg != IDLE) ||
                    inflight_reg || (oq_count_reg != 2'd0);

`ifdef NB_ID_FIFO_OVF_CHECK_EN
  logic ovf_reg;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ovf_reg <= 1'b0;
    else if (bus.in_valid && (count_reg == FULL_CNT))
      ovf_reg <= 1'b1;
  end
  assign bus.overflow_err = ovf_reg;
`else
  assign bus.overflow_err = 1'b0;
`endif
endmodule
